// File: rtl/motor_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for the Motor_PWM duty input: ramps duty one
// step per RAMP_DIV clocks toward a commanded target, with emergency stop.
module motor_ramp_ctrl #(
  parameter int DUTY_W   = 4,
  parameter int RAMP_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_speed,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty,
  output logic              motor_en,
  output logic              at_target,
  output logic [7:0]        state_led
);

  localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_DIV - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    RAMP_UP   = 4'b0010,
    RAMP_DOWN = 4'b0100,
    HOLD      = 4'b1000,
    ESTOP     = 4'b1111
  } state_t;

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [PS_W-1:0]   prescaler;
  logic [DUTY_W-1:0] duty_up;
  logic [DUTY_W-1:0] duty_dn;
  logic              step;
  logic              idle_or_hold;

  assign duty_up      = duty + DUTY_W'(1);
  assign duty_dn      = duty - DUTY_W'(1);
  assign step         = (prescaler == PS_LAST);
  assign idle_or_hold = (state == IDLE) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty      <= '0;
      target    <= '0;
      prescaler <= '0;
    end else if (estop) begin
      // estop outranks both command acceptance and ramp steps
      state     <= ESTOP;
      duty      <= '0;
      target    <= '0;
      prescaler <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (cmd_valid) begin
            target    <= cmd_speed;
            prescaler <= '0;
            if (cmd_speed > duty)
              state <= RAMP_UP;
            else if (cmd_speed < duty)
              state <= RAMP_DOWN;
            else
              state <= (cmd_speed != '0) ? HOLD : IDLE;
          end
        end
        RAMP_UP: begin
          if (step) begin
            prescaler <= '0;
            duty      <= duty_up;
            if (duty_up == target)
              state <= HOLD;
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end
        RAMP_DOWN: begin
          if (step) begin
            prescaler <= '0;
            duty      <= duty_dn;
            if (duty_dn == target)
              state <= (target != '0) ? HOLD : IDLE;
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end
        ESTOP: begin
          state     <= IDLE;
          prescaler <= '0;
        end
        default: begin
          state     <= IDLE;
          duty      <= '0;
          target    <= '0;
          prescaler <= '0;
        end
      endcase
    end
  end

  // Outputs depend only on registered state, so estop reaches cmd_ready
  // through the ESTOP state on the edge that samples it.
  assign cmd_ready = idle_or_hold;
  assign at_target = idle_or_hold;
  assign motor_en  = (duty != '0) && (state != ESTOP);
  assign state_led = {4'(duty), 4'(state)};

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl (RAMP_DIV=4): stimulus pushes expected
// status snapshots with their cycle stamps; a negedge monitor pops on change.
module tb_motor_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_speed;
  logic       estop;
  logic [3:0] duty;
  logic       motor_en;
  logic       at_target;
  logic [7:0] state_led;

  motor_ramp_ctrl #(.DUTY_W(4), .RAMP_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_speed (cmd_speed),
    .estop     (estop),
    .duty      (duty),
    .motor_en  (motor_en),
    .at_target (at_target),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // obs = {cmd_ready, motor_en, at_target, state_led}
  typedef struct {
    int          cyc;
    logic [10:0] obs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic push(input int c, input logic [7:0] led, input logic rdy,
                      input logic en, input logic at);
    exp_t e;
    e.cyc = c;
    e.obs = {rdy, en, at, led};
    exp_q.push_back(e);
  endtask

  // Expected snapshots for a ramp accepted at edge e0, limited to nsteps steps.
  task automatic push_ramp(input int e0, input int from, input int to, input int nsteps);
    logic [3:0] code;
    logic [3:0] d;
    int         dir;
    int         total;
    dir   = (to > from) ? 1 : -1;
    total = (to > from) ? to - from : from - to;
    code  = (to > from) ? 4'b0010 : 4'b0100;
    d     = 4'(from);
    push(e0, {d, code}, 1'b0, d != 4'd0, 1'b0);
    for (int k = 1; k <= nsteps; k++) begin
      d = 4'(from + dir * k);
      if (k == total)
        push(e0 + 4 * k, {d, (d != 4'd0) ? 4'b1000 : 4'b0001}, 1'b1, d != 4'd0, 1'b1);
      else
        push(e0 + 4 * k, {d, code}, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input int speed, input int from);
    int e0;
    e0 = cyc + 1;
    if (speed != from)
      push_ramp(e0, from, speed, (speed > from) ? speed - from : from - speed);
    cmd_valid = 1'b1;
    cmd_speed = 4'(speed);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected snapshots still pending at cycle %0d, required 0",
               exp_q.size(), cyc);
      exp_q.delete();
    end
    tick(2);
  endtask

  logic [10:0] prev = '1;
  always begin
    logic [10:0] obs;
    exp_t        e;
    @(negedge clk);
    obs = {cmd_ready, motor_en, at_target, state_led};
    if (obs !== prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected: cycle %0d got obs=%h, required no change from %h",
                 cyc, obs, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.obs !== obs || e.cyc != cyc) begin
          miscompares++;
          $display("FAIL snapshot: got obs=%h at cycle %0d, required obs=%h at cycle %0d",
                   obs, cyc, e.obs, e.cyc);
        end else begin
          $display("ok  cycle %0d ready=%b en=%b at=%b led=%h",
                   cyc, obs[10], obs[9], obs[8], obs[7:0]);
        end
      end
      prev = obs;
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      e = exp_q.pop_front();
      $display("FAIL stall: cycle %0d obs stayed %h, required %h by cycle %0d",
               cyc, obs, e.obs, e.cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_speed = 4'd0;
    estop     = 1'b0;
    push(1, 8'h01, 1'b1, 1'b0, 1'b1);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Ramp up 0 -> 12, then down 12 -> 5 -> 0
    send_cmd(12, 0);
    drain(100);
    send_cmd(5, 12);
    drain(100);
    send_cmd(0, 5);
    drain(100);

    // Busy rejection: command during RAMP_UP is ignored
    send_cmd(10, 0);
    tick(6);
    cmd_valid = 1'b1;
    cmd_speed = 4'd2;
    tick(1);
    cmd_valid = 1'b0;
    drain(100);
    send_cmd(0, 10);
    drain(100);

    // Emergency stop at duty 7 with a command held throughout
    e0 = cyc + 1;
    push_ramp(e0, 0, 12, 7);
    cmd_valid = 1'b1;
    cmd_speed = 4'd12;
    tick(1);
    cmd_valid = 1'b0;
    while (cyc < e0 + 28) tick(1);
    estop     = 1'b1;
    cmd_valid = 1'b1;
    cmd_speed = 4'd3;
    push(cyc + 1, 8'h0F, 1'b0, 1'b0, 1'b0);
    tick(4);
    estop = 1'b0;
    push(cyc + 1, 8'h01, 1'b1, 1'b0, 1'b1);
    push_ramp(cyc + 2, 0, 3, 3);
    tick(2);
    cmd_valid = 1'b0;
    drain(100);

    // Asynchronous reset mid-ramp at duty 6, between clock edges
    e0 = cyc + 1;
    push_ramp(e0, 3, 12, 3);
    cmd_valid = 1'b1;
    cmd_speed = 4'd12;
    tick(1);
    cmd_valid = 1'b0;
    while (cyc < e0 + 12) tick(1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(cyc, 8'h01, 1'b1, 1'b0, 1'b1);
    tick(2);
    rst_n = 1'b1;
    drain(20);

    // Equal target holds; command and estop on the same edge drops the command
    send_cmd(9, 0);
    drain(100);
    send_cmd(9, 9);
    tick(5);
    estop     = 1'b1;
    cmd_valid = 1'b1;
    cmd_speed = 4'd2;
    push(cyc + 1, 8'h0F, 1'b0, 1'b0, 1'b0);
    tick(1);
    estop     = 1'b0;
    cmd_valid = 1'b0;
    push(cyc + 1, 8'h01, 1'b1, 1'b0, 1'b1);
    tick(12);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
